matrix_edit_ctrl: RTL and testbench
===================================

// Module: matrix_edit_ctrl
// PURPOSE
//  Keypad-driven frame-buffer controller for the 8x8 red/green dot-matrix driver.
//  - Holds the 64-pixel, 2-bit-per-pixel picture and a cursor.
//  - Turns debounced 4x4 keypad levels into move, paint, erase and clear commands.
//  - Drives the 128-bit frame input of the matrix driver, with an optional blinking cursor overlay.
//  - Sits between the keypad Debounce output and the Matrix frame input.
// PARAMETERS
//  BLINK_DIV  12_500_000  clk cycles per cursor-blink half-period; legal range >=2.
//  INIT_ROW   0           cursor row after reset, 0..7.
//  INIT_COL   0           cursor column after reset, 0..7.
// PORTS
//  clk      in   1    system clock; everything is on its rising edge.
//  rst      in   1    reset; synchronous, active-high.
//  key_i    in   16   debounced key levels; bit k = key k; 1 = pressed.
//  frame_o  out  128  picture to the matrix driver.
//  cur_row  out  3    cursor row.
//  cur_col  out  3    cursor column.
//  busy_o   out  1    high while a clear sweep runs.
// BEHAVIOUR
//  Frame format
//  - Pixel p = 8*row + col; its two bits are frame_o[127-2p -: 2].
//  - Row 0, column 0 is the MSB pair.
//  - Colour code: bit1 = red, bit0 = green. 00 off, 01 green, 10 red, 11 amber.
//  Reset values
//  - Frame buffer all 0. frame_o = 128'h0.
//  - cur_row = INIT_ROW, cur_col = INIT_COL. busy_o = 0.
//  - Blink counter = 0, blink phase = 0.
//  - Key history key_q = 16'hFFFF, so keys held through reset never fire.
//  Edge detection
//  - key_q <= key_i on every cycle, including while busy.
//  - press = key_i & ~key_q.
//  - A command executes at the first edge that samples key_i high.
//  - Its effect is visible on the outputs right after that edge: 1-cycle latency.
//  Command keys
//  - 1: row-1. 9: row+1. 4: col-1. 6: col+1. All wrap modulo 8 (7+1 -> 0, 0-1 -> 7).
//  - 5: cursor pixel colour steps 00 -> 01 -> 10 -> 11 -> 00.
//  - 2: cursor pixel set to 00.
//  - 0: start clear sweep.
//  - All other keys are ignored.
//  Simultaneous presses
//  - Of the command keys that have a press in the same cycle, only the lowest index executes.
//  - Presses on the other keys in that cycle are discarded and never replayed.
//  FSM IDLE/CLEAR
//  - IDLE: executes commands.
//  - Key 0 -> CLEAR. At that same edge: busy_o = 1, row counter = 0.
//  - CLEAR: each cycle zeroes 16 bits (one row) and increments the row counter.
//  - Rows 0..7 are cleared over 8 consecutive edges.
//  - The edge that clears row 7 returns the FSM to IDLE and sets busy_o = 0.
//  - busy_o stays high for exactly 8 cycles.
//  - All presses while in CLEAR are discarded. The cursor is unchanged by a clear.
//  - rst during CLEAR: immediate full reset; no partial rows survive.
//  Blink
//  - Counter runs 0..BLINK_DIV-1. At the terminal count it wraps to 0 and toggles the phase.
//  - Any executed command forces counter = 0 and phase = 1, so the cursor is visible at once.
//  - frame_o = buffer, except that when phase = 1 and busy_o = 0 the cursor pixel is
//    shown XOR 2'b11.
//  - The overlay is output-only; the buffer keeps the true colour.
// CONFIGURATION
//  MATRIX_EDIT_BLINK_EN
//  - Defined: blink counter and overlay present, as described above.
//  - Undefined: no counter; frame_o = buffer at all times; the cursor is visible only
//    through cur_row/cur_col; BLINK_DIV is unused.
// TESTING
//  All tests use BLINK_DIV=4.
//  1. Hold key_i=16'h0020 across the rst release, then keep it held.
//     -> No colour change. After release and re-press, pixel (0,0) = 01:
//        frame_o[127:126] = 2'b01 in the buffer.
//  2. From (0,0): press key 1 once, then key 4 once.
//     -> cur_row = 7, then cur_col = 7 (wrap). A second key-1 press gives cur_row = 6.
//  3. At (2,3): press key 5 four times.
//     -> Pixel 19 cycles through 01, 10, 11, 00; frame_o[89:88] follows.
//        Key 2 after a single press returns it to 00.
//  4. Paint several pixels, press key 0, and press key 5 during busy.
//     -> busy_o is high for exactly 8 cycles, then frame_o = 0.
//        The key-5 press is ignored and the cursor is unchanged.
//  5. Press key_i=16'h0212 (keys 1, 4 and 9) in one cycle.
//     -> Only key 1 executes (row-1). Holding the keys causes no later action.
//  6. With BLINK_EN, cursor on pixel 00 and idle.
//     -> The cursor pair alternates 11/00 every 4 cycles. Any command shows 11 on the next cycle.
//  7. Assert rst during cycle 3 of a clear.
//     -> All outputs return to their reset values on the next edge.

Source files
------------

// File: rtl/matrix_edit_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : matrix_edit_ctrl
//  Description : Keypad-driven frame-buffer controller for an 8x8 red/green
//                dot matrix. Holds a 64-pixel, 2-bit-per-pixel picture and a
//                cursor. Rising edges of debounced key levels become move,
//                paint, erase and clear commands. The picture drives the
//                128-bit matrix frame input.
//                Optional feature macro: MATRIX_EDIT_BLINK_EN
//                  defined   -> blinking cursor overlay on frame_o
//                  undefined -> frame_o is the raw buffer, BLINK_DIV unused
//  Revision    : 1.0 - initial release
// ============================================================================
module matrix_edit_ctrl #(
    parameter int BLINK_DIV = 12_500_000,
    parameter int INIT_ROW  = 0,
    parameter int INIT_COL  = 0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [15:0]  key_i,
    output logic [127:0] frame_o,
    output logic [2:0]   cur_row,
    output logic [2:0]   cur_col,
    output logic         busy_o
);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_CLEAR = 1'b1
    } state_t;

    localparam logic [2:0]  C_INIT_ROW = 3'(INIT_ROW);
    localparam logic [2:0]  C_INIT_COL = 3'(INIT_COL);
    // Keys that carry a command: 0,1,2,4,5,6,9
    localparam logic [15:0] C_CMD_MASK = 16'h0277;

    // A blink half-period shorter than two cycles cannot be counted
    if (BLINK_DIV < 2) begin : g_bad_blink_div
        $error("matrix_edit_ctrl: BLINK_DIV must be >= 2");
    end

    state_t         state_q, state_d;
    logic [127:0]   buf_q, buf_d;
    logic [2:0]     row_q, row_d;
    logic [2:0]     col_q, col_d;
    logic [2:0]     clr_q, clr_d;
    logic           busy_q, busy_d;
    logic [15:0]    key_q;

    logic [15:0]    w_press;
    logic [15:0]    w_cmd;
    logic [15:0]    w_sel;
    logic [6:0]     w_cur_lsb;
    logic [6:0]     w_clr_lsb;
    logic [1:0]     w_cur_pix;

    // Rising edges on command keys; only the lowest-index one survives
    assign w_press = key_i & ~key_q;
    assign w_cmd   = w_press & C_CMD_MASK;
    assign w_sel   = w_cmd & (~w_cmd + 16'd1);

    // Pixel p = 8*row+col lives at [127-2p -: 2], i.e. LSB at 126-2p
    assign w_cur_lsb = 7'd126 - {row_q, col_q, 1'b0};
    assign w_cur_pix = buf_q[w_cur_lsb +: 2];
    // Row r occupies [127-16r -: 16], i.e. LSB at 112-16r
    assign w_clr_lsb = 7'd112 - {clr_q, 4'b0000};

    // Next-state logic: command decode in IDLE, one row per cycle in CLEAR
    always_comb begin
        state_d = state_q;
        buf_d   = buf_q;
        row_d   = row_q;
        col_d   = col_q;
        clr_d   = clr_q;
        busy_d  = busy_q;
        case (state_q)
            S_IDLE: begin
                case (w_sel)
                    16'h0001: begin
                        state_d = S_CLEAR;
                        busy_d  = 1'b1;
                        clr_d   = 3'd0;
                    end
                    16'h0002: row_d = row_q - 3'd1;
                    16'h0004: buf_d[w_cur_lsb +: 2] = 2'b00;
                    16'h0010: col_d = col_q - 3'd1;
                    16'h0020: buf_d[w_cur_lsb +: 2] = w_cur_pix + 2'd1;
                    16'h0040: col_d = col_q + 3'd1;
                    16'h0200: row_d = row_q + 3'd1;
                    default: ;
                endcase
            end
            S_CLEAR: begin
                buf_d[w_clr_lsb +: 16] = 16'h0000;
                clr_d = clr_q + 3'd1;
                if (clr_q == 3'd7) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State registers; key history resets high so held keys never fire
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            buf_q   <= '0;
            row_q   <= C_INIT_ROW;
            col_q   <= C_INIT_COL;
            clr_q   <= 3'd0;
            busy_q  <= 1'b0;
            key_q   <= 16'hFFFF;
        end else begin
            state_q <= state_d;
            buf_q   <= buf_d;
            row_q   <= row_d;
            col_q   <= col_d;
            clr_q   <= clr_d;
            busy_q  <= busy_d;
            key_q   <= key_i;
        end
    end

    assign cur_row = row_q;
    assign cur_col = col_q;
    assign busy_o  = busy_q;

`ifdef MATRIX_EDIT_BLINK_EN
    localparam int            C_CW = $clog2(BLINK_DIV);
    localparam logic [C_CW-1:0] C_BLINK_TC = C_CW'(BLINK_DIV - 1);

    logic [C_CW-1:0] blink_cnt_q, blink_cnt_d;
    logic            phase_q, phase_d;
    logic            w_exec;

    // Any command accepted in IDLE restarts the blink with the cursor shown
    assign w_exec = (state_q == S_IDLE) && (|w_sel);

    // Blink half-period counter and phase
    always_comb begin
        blink_cnt_d = blink_cnt_q;
        phase_d     = phase_q;
        if (w_exec) begin
            blink_cnt_d = '0;
            phase_d     = 1'b1;
        end else if (blink_cnt_q == C_BLINK_TC) begin
            blink_cnt_d = '0;
            phase_d     = ~phase_q;
        end else begin
            blink_cnt_d = blink_cnt_q + 1'b1;
        end
    end

    // Blink registers
    always_ff @(posedge clk) begin
        if (rst) begin
            blink_cnt_q <= '0;
            phase_q     <= 1'b0;
        end else begin
            blink_cnt_q <= blink_cnt_d;
            phase_q     <= phase_d;
        end
    end

    // Output view: cursor pixel inverted while shown; buffer keeps true colour
    always_comb begin
        frame_o = buf_q;
        if (phase_q && !busy_q) begin
            frame_o[w_cur_lsb +: 2] = w_cur_pix ^ 2'b11;
        end
    end
`else
    // Without blink the matrix sees the raw buffer
    assign frame_o = buf_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_matrix_edit_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_matrix_edit_ctrl
//  Description : Directed, table-driven bench for matrix_edit_ctrl with
//                hand-written sequences for clear, reset-in-clear and blink.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_matrix_edit_ctrl;

`ifdef MATRIX_EDIT_BLINK_EN
    localparam bit BLINK_ON = 1'b1;
`else
    localparam bit BLINK_ON = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic [15:0]  key_i;
    logic [127:0] frame_o;
    logic [2:0]   cur_row;
    logic [2:0]   cur_col;
    logic         busy_o;

    int n_tests = 0;
    int n_fail  = 0;

    matrix_edit_ctrl #(
        .BLINK_DIV (4),
        .INIT_ROW  (0),
        .INIT_COL  (0)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .key_i   (key_i),
        .frame_o (frame_o),
        .cur_row (cur_row),
        .cur_col (cur_col),
        .busy_o  (busy_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] key;
        logic [2:0]  row;
        logic [2:0]  col;
        logic [1:0]  pix;
        logic        busy;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [15:0] k(input int n);
        return 16'(1 << n);
    endfunction

    function automatic void add(input logic [15:0] key, input int r, input int c,
                                input int p);
        vec_t v;
        v.key  = key;
        v.row  = 3'(r);
        v.col  = 3'(c);
        v.pix  = 2'(p);
        v.busy = 1'b0;
        vecs.push_back(v);
    endfunction

    function automatic logic [1:0] pix_at(input logic [127:0] f, input logic [2:0] r,
                                          input logic [2:0] c);
        int p;
        p = 8 * int'(r) + int'(c);
        return f[127 - 2*p -: 2];
    endfunction

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Cursor pixel may carry the blink overlay when the feature is built in
    task automatic chk_pix(input string name, input logic [1:0] got, input logic [1:0] exp);
        n_tests++;
        if (!(got === exp || (BLINK_ON && got === (exp ^ 2'b11)))) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, got, exp);
        end
    endtask

    task automatic chk_frame(input string name, input logic [127:0] exp,
                             input logic [2:0] r, input logic [2:0] c);
        logic [127:0] m;
        int p;
        m = '1;
        p = 8 * int'(r) + int'(c);
        if (BLINK_ON) m[127 - 2*p -: 2] = 2'b00;
        n_tests++;
        if ((frame_o & m) !== (exp & m)) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, frame_o, exp);
        end
    endtask

    task automatic step(input logic [15:0] key);
        @(negedge clk);
        key_i = key;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [127:0] exp_f;
        int busy_cnt;
        logic [1:0] exp_p;

        // Reset-hold check, arrows with wrap, ignored key
        add(16'h0020, 0, 0, 0); add(16'h0020, 0, 0, 0);
        add(16'h0000, 0, 0, 0); add(16'h0020, 0, 0, 1); add(16'h0000, 0, 0, 1);
        add(k(3), 0, 0, 1);     add(16'h0000, 0, 0, 1);
        add(k(1), 7, 0, 0);     add(16'h0000, 7, 0, 0);
        add(k(4), 7, 7, 0);     add(16'h0000, 7, 7, 0);
        add(k(1), 6, 7, 0);     add(16'h0000, 6, 7, 0);
        for (int i = 1; i <= 4; i++) begin
            add(k(9), (6 + i) % 8, 7, 0); add(16'h0000, (6 + i) % 8, 7, 0);
        end
        for (int i = 0; i <= 3; i++) begin
            add(k(6), 2, i, 0); add(16'h0000, 2, i, 0);
        end
        // Colour stepping at (2,3), then erase
        for (int i = 1; i <= 4; i++) begin
            add(k(5), 2, 3, i % 4); add(16'h0000, 2, 3, i % 4);
        end
        add(k(5), 2, 3, 1); add(16'h0000, 2, 3, 1);
        add(k(2), 2, 3, 0); add(16'h0000, 2, 3, 0);
        // Simultaneous presses: lowest index only, holding does nothing more
        add(16'h0212, 1, 3, 0); add(16'h0212, 1, 3, 0); add(16'h0212, 1, 3, 0);
        add(16'h0000, 1, 3, 0);
        add(16'h0060, 1, 3, 1); add(16'h0000, 1, 3, 1);

        rst   = 1'b1;
        key_i = 16'h0020;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_frame", frame_o, 128'h0);
        chk("rst_row",   cur_row, 0);
        chk("rst_col",   cur_col, 0);
        chk("rst_busy",  busy_o,  0);
        @(negedge clk);
        rst = 1'b0;

        foreach (vecs[i]) begin
            step(vecs[i].key);
            chk($sformatf("vec%0d_row", i),  cur_row, vecs[i].row);
            chk($sformatf("vec%0d_col", i),  cur_col, vecs[i].col);
            chk($sformatf("vec%0d_busy", i), busy_o,  vecs[i].busy);
            chk_pix($sformatf("vec%0d_pix", i),
                    pix_at(frame_o, vecs[i].row, vecs[i].col), vecs[i].pix);
        end
        chk("pix19_bits", frame_o[89:88], 2'b00);

        // Clear sweep with a key-5 press while busy
        exp_f = '0;
        exp_f[127:126] = 2'b01;
        exp_f[105:104] = 2'b01;
        chk_frame("pre_clear", exp_f, 3'd1, 3'd3);
        busy_cnt = 0;
        step(k(0));
        if (busy_o) busy_cnt++;
        chk("clr_enter_busy", busy_o, 1);
        chk_frame("clr_enter_frame", exp_f, 3'd1, 3'd3);
        step(16'h0000);
        if (busy_o) busy_cnt++;
        exp_f[127:126] = 2'b00;
        chk_frame("clr_row0", exp_f, 3'd1, 3'd3);
        step(k(5));
        if (busy_o) busy_cnt++;
        chk("clr_row1", frame_o, 128'h0);
        step(16'h0000);
        if (busy_o) busy_cnt++;
        for (int i = 0; i < 20 && busy_o; i++) begin
            step(16'h0000);
            if (busy_o) busy_cnt++;
        end
        chk("clr_busy_cycles", busy_cnt, 8);
        chk("clr_done_busy", busy_o, 0);
        chk_frame("clr_done_frame", 128'h0, 3'd1, 3'd3);
        chk_pix("clr_cursor_pix", pix_at(frame_o, 3'd1, 3'd3), 2'b00);
        chk("clr_row", cur_row, 1);
        chk("clr_col", cur_col, 3);

        // Reset in the middle of a clear
        step(k(5));
        chk_pix("rc_paint", pix_at(frame_o, 3'd1, 3'd3), 2'b01);
        step(16'h0000);
        step(k(0));
        step(16'h0000);
        step(16'h0000);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rc_frame", frame_o, 128'h0);
        chk("rc_row",   cur_row, 0);
        chk("rc_col",   cur_col, 0);
        chk("rc_busy",  busy_o,  0);
        @(negedge clk);
        rst = 1'b0;
        step(16'h0000);
        chk("rc_after_busy",  busy_o,  0);
        chk("rc_after_frame", frame_o, 128'h0);

        // Blink: command shows cursor at once, then 4-cycle half-periods
        step(k(2));
        for (int s = 0; s < 6; s++) begin
            if (s > 0) step(16'h0000);
            exp_p = (BLINK_ON && ((s / 4) % 2 == 0)) ? 2'b11 : 2'b00;
            chk($sformatf("blink_s%0d", s), pix_at(frame_o, 3'd0, 3'd0), exp_p);
        end
        step(k(6));
        chk("blink_cmd_col", cur_col, 1);
        chk("blink_cmd_pix", pix_at(frame_o, 3'd0, 3'd1), BLINK_ON ? 2'b11 : 2'b00);
        chk("blink_old_pix", pix_at(frame_o, 3'd0, 3'd0), 2'b00);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
